// File: rtl/apb_pkg.sv
// Shared APB definitions for the register-bank slave: bus widths, FSM state
// encoding and the pslverr response codes.
package apb_pkg;

  localparam int APB_DATA_W = 32;
  localparam int APB_ADDR_W = 32;

  // Two-state transfer FSM, kept as plain logic constants so older tools and
  // netlists see a simple bit encoding.
  typedef logic [0:0] apb_state_t;
  localparam apb_state_t ST_IDLE   = 1'b0;
  localparam apb_state_t ST_ACCESS = 1'b1;

  localparam logic PSLVERR_OKAY = 1'b0;
  localparam logic PSLVERR_ERR  = 1'b1;

endpackage

// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between one master and the register-bank slave.
// The master drives the request side, the slave drives the response side.
interface apb_slave_regfile_if;
  import apb_pkg::*;

  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [APB_ADDR_W-1:0] paddr;
  logic [APB_DATA_W-1:0] pwdata;
  logic [APB_DATA_W-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_slave_regfile.sv
// APB slave register bank: NUM_REGS 32-bit read/write registers exposed as a
// flat bus, with optional wait states in the access phase.
// Optional feature macro: APB_SLV_IRQ_EN adds an irq output that pulses for
// one cycle after every committed valid write.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int NUM_REGS    = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  apb_slave_regfile_if.slave             apb,
  output logic [NUM_REGS*APB_DATA_W-1:0] reg_out
`ifdef APB_SLV_IRQ_EN
  ,
  output logic                           irq
`endif
);

  localparam int         IDX_W     = $clog2(NUM_REGS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  apb_state_t                           state_q, state_d;
  logic [3:0]                           cnt_q, cnt_d;
  logic [APB_DATA_W-1:0]                prdata_q, prdata_d;
  logic                                 pready_q, pready_d;
  logic                                 pslverr_q, pslverr_d;
  logic [NUM_REGS-1:0][APB_DATA_W-1:0]  regs_q;

  logic [IDX_W-1:0]      regIdx;
  logic                  addrInvalid;
  logic                  wrCommit;
  logic [APB_DATA_W-1:0] rdValue;
  logic                  respErr;

  // Address decode: word-aligned and inside the bank; everything above the
  // index bits must be zero because NUM_REGS is a power of two.
  always_comb begin
    regIdx      = apb.paddr[IDX_W+1:2];
    addrInvalid = (apb.paddr[1:0] != 2'b00) ||
                  (apb.paddr[APB_ADDR_W-1:IDX_W+2] != '0);
    rdValue     = addrInvalid ? '0 : regs_q[regIdx];
    respErr     = addrInvalid ? PSLVERR_ERR : PSLVERR_OKAY;
    wrCommit    = (state_q == ST_ACCESS) && pready_q && apb.psel &&
                  apb.penable && apb.pwrite && !addrInvalid;
  end

  // Transfer FSM: the response is loaded one edge early so that pready,
  // prdata and pslverr are all registered outputs in the completing cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prdata_d  = prdata_q;
    pready_d  = 1'b0;
    pslverr_d = PSLVERR_OKAY;
    case (state_q)
      ST_IDLE: begin
        if (apb.psel && !apb.penable) begin
          state_d = ST_ACCESS;
          cnt_d   = WAIT_INIT;
          if (WAIT_INIT == 4'd0) begin
            pready_d  = 1'b1;
            pslverr_d = respErr;
            if (!apb.pwrite) begin
              prdata_d = rdValue;
            end
          end
        end
      end
      default: begin
        if (pready_q || !apb.psel) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (apb.penable) begin
          if (cnt_q > 4'd1) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            cnt_d     = 4'd0;
            pready_d  = 1'b1;
            pslverr_d = respErr;
            if (!apb.pwrite) begin
              prdata_d = rdValue;
            end
          end
        end
      end
    endcase
  end

  // FSM, wait counter and response registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= PSLVERR_OKAY;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  // Register bank: a write lands at the edge ending the completing cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '0;
    end else if (wrCommit) begin
      regs_q[regIdx] <= apb.pwdata;
    end
  end

  assign apb.prdata  = prdata_q;
  assign apb.pready  = pready_q;
  assign apb.pslverr = pslverr_q;
  assign reg_out     = regs_q;

`ifdef APB_SLV_IRQ_EN
  logic irq_q;

  // One-cycle interrupt pulse following each committed write.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= wrCommit;
    end
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Self-checking bench for apb_slave_regfile: three instances with
// WAIT_STATES 0, 3 and 2 driven by directed and randomized APB transfers,
// checked against an array model of the register bank.
module tb_apb_slave_regfile;
  import apb_pkg::*;

  localparam int         NU      = 3;
  localparam int         NREG    = 8;
  localparam int         IW      = 3;
  localparam logic [11:0] WS_PACK = {4'd2, 4'd3, 4'd0};

  logic clk;
  logic rstV    [NU];
  logic pselV   [NU];
  logic penV    [NU];
  logic pwrV    [NU];
  logic [APB_ADDR_W-1:0] addrV [NU];
  logic [APB_DATA_W-1:0] wdV   [NU];
  logic [APB_DATA_W-1:0] prdataV  [NU];
  logic                  preadyV  [NU];
  logic                  pslverrV [NU];
  logic [NREG*APB_DATA_W-1:0] regOutV [NU];
  logic                  irqV [NU];

  logic [31:0] mdl [NU][NREG];
  int expIrq  [NU];
  int seenIrq [NU];
  int vectors;
  int miscompares;

  for (genvar g = 0; g < NU; g++) begin : gU
    apb_slave_regfile_if bus ();
    assign bus.psel     = pselV[g];
    assign bus.penable  = penV[g];
    assign bus.pwrite   = pwrV[g];
    assign bus.paddr    = addrV[g];
    assign bus.pwdata   = wdV[g];
    assign prdataV[g]   = bus.prdata;
    assign preadyV[g]   = bus.pready;
    assign pslverrV[g]  = bus.pslverr;

    apb_slave_regfile #(
      .NUM_REGS    (NREG),
      .WAIT_STATES (int'(WS_PACK[4*g +: 4]))
    ) dut (
      .clk     (clk),
      .reset   (rstV[g]),
      .apb     (bus),
      .reg_out (regOutV[g])
`ifdef APB_SLV_IRQ_EN
      ,
      .irq     (irqV[g])
`endif
    );
`ifndef APB_SLV_IRQ_EN
    assign irqV[g] = 1'b0;
`endif
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int wsOf(input int u);
    return int'(WS_PACK[4*u +: 4]);
  endfunction

  function automatic bit isInvalid(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || (addr[31:2] >= 30'(NREG));
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic checkRegs(input int u);
    for (int i = 0; i < NREG; i++) begin
      checkOutput($sformatf("u%0d reg_out[%0d]", u, i),
                  regOutV[u][32*i +: 32], mdl[u][i]);
    end
  endtask

  task automatic clearModel(input int u);
    for (int i = 0; i < NREG; i++) mdl[u][i] = '0;
  endtask

  // One complete APB transfer; called at #1 after a rising edge and returns
  // at #1 after the completion edge, so consecutive calls are back-to-back.
  task automatic applyStimulus(input int u, input bit wr,
                               input logic [31:0] addr, input logic [31:0] data);
    bit          inv;
    bit          done;
    int          n;
    logic [31:0] expRd;
    inv   = isInvalid(addr);
    expRd = inv ? 32'h0 : mdl[u][addr[2 +: IW]];
    pselV[u] = 1'b1; penV[u] = 1'b0; pwrV[u] = wr; addrV[u] = addr; wdV[u] = data;
    @(negedge clk);
    checkOutput($sformatf("u%0d setup pready", u), 32'(preadyV[u]), 32'h0);
    @(posedge clk); #1;
    penV[u] = 1'b1;
    n = 0;
    done = 1'b0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (preadyV[u]) begin
        done = 1'b1;
        checkOutput($sformatf("u%0d latency", u), 32'(n), 32'(wsOf(u) + 1));
        checkOutput($sformatf("u%0d pslverr", u), 32'(pslverrV[u]), 32'(inv));
        if (!wr) checkOutput($sformatf("u%0d prdata", u), prdataV[u], expRd);
      end
      @(posedge clk); #1;
    end
    if (!done) checkOutput($sformatf("u%0d pready timeout", u), 32'(preadyV[u]), 32'h1);
    pselV[u] = 1'b0; penV[u] = 1'b0;
    if (wr && !inv) begin
      mdl[u][addr[2 +: IW]] = data;
      expIrq[u]++;
    end
    checkOutput($sformatf("u%0d pready drop", u), 32'(preadyV[u]), 32'h0);
    checkOutput($sformatf("u%0d pslverr drop", u), 32'(pslverrV[u]), 32'h0);
    if (!wr && done) checkOutput($sformatf("u%0d prdata hold", u), prdataV[u], expRd);
`ifdef APB_SLV_IRQ_EN
    checkOutput($sformatf("u%0d irq", u), 32'(irqV[u]), 32'(wr && !inv));
`endif
    checkRegs(u);
  endtask

  // Starts a transfer, waits some access cycles, then aborts it by dropping
  // psel or by pulsing reset; no completion and no write may happen.
  task automatic applyAbort(input int u, input logic [31:0] addr,
                            input logic [31:0] data, input int waits,
                            input bit byReset);
    pselV[u] = 1'b1; penV[u] = 1'b0; pwrV[u] = 1'b1; addrV[u] = addr; wdV[u] = data;
    @(posedge clk); #1;
    penV[u] = 1'b1;
    for (int k = 0; k < waits; k++) begin
      @(negedge clk);
      checkOutput($sformatf("u%0d abort wait pready", u), 32'(preadyV[u]), 32'h0);
      @(posedge clk); #1;
    end
    if (byReset) rstV[u] = 1'b1;
    else begin
      pselV[u] = 1'b0; penV[u] = 1'b0;
    end
    @(negedge clk);
    checkOutput($sformatf("u%0d abort pready", u), 32'(preadyV[u]), 32'h0);
    @(posedge clk); #1;
    rstV[u] = 1'b0; pselV[u] = 1'b0; penV[u] = 1'b0;
    if (byReset) clearModel(u);
    @(negedge clk);
    checkOutput($sformatf("u%0d post-abort pready", u), 32'(preadyV[u]), 32'h0);
    checkRegs(u);
    @(posedge clk); #1;
  endtask

`ifdef APB_SLV_IRQ_EN
  always @(negedge clk) begin
    for (int u = 0; u < NU; u++) if (irqV[u] === 1'b1) seenIrq[u]++;
  end
`endif

  initial begin
    logic [31:0] a;
    int          r;
    vectors = 0;
    miscompares = 0;
    for (int u = 0; u < NU; u++) begin
      rstV[u] = 1'b1; pselV[u] = 1'b0; penV[u] = 1'b0; pwrV[u] = 1'b0;
      addrV[u] = '0; wdV[u] = '0; expIrq[u] = 0; seenIrq[u] = 0;
      clearModel(u);
    end
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < NU; u++) rstV[u] = 1'b0;

    for (int u = 0; u < NU; u++) begin
      checkOutput($sformatf("u%0d reset pready", u), 32'(preadyV[u]), 32'h0);
      checkOutput($sformatf("u%0d reset pslverr", u), 32'(pslverrV[u]), 32'h0);
      checkOutput($sformatf("u%0d reset prdata", u), prdataV[u], 32'h0);
      checkRegs(u);
    end

    applyStimulus(0, 1'b0, 32'h0, 32'h0);
    applyStimulus(0, 1'b1, 32'h8, 32'h0000_00A5);
    applyStimulus(0, 1'b0, 32'h8, 32'h0);
    applyStimulus(0, 1'b1, 32'h20, 32'hFFFF_FFFF);
    applyStimulus(0, 1'b1, 32'h6, 32'h1234_5678);
    applyStimulus(0, 1'b0, 32'h20, 32'h0);
    applyStimulus(0, 1'b1, 32'h1C, 32'hCAFE_0001);
    applyStimulus(0, 1'b1, 32'h0, 32'hCAFE_0002);
    applyStimulus(0, 1'b1, 32'h8000_0004, 32'hDEAD_BEEF);

    pselV[0] = 1'b1; penV[0] = 1'b1; pwrV[0] = 1'b1; addrV[0] = 32'h4; wdV[0] = 32'h5A5A_5A5A;
    repeat (2) begin
      @(negedge clk);
      checkOutput("u0 stray penable pready", 32'(preadyV[0]), 32'h0);
      @(posedge clk); #1;
    end
    pselV[0] = 1'b0; penV[0] = 1'b0;
    checkRegs(0);

    applyStimulus(1, 1'b0, 32'h4, 32'h0);
    applyStimulus(1, 1'b1, 32'h4, 32'h0BAD_F00D);
    applyStimulus(1, 1'b0, 32'h4, 32'h0);
    applyStimulus(1, 1'b1, 32'h21, 32'h1111_1111);

    applyStimulus(2, 1'b1, 32'h10, 32'h7777_0010);
    applyAbort(2, 32'h10, 32'h9999_9999, 1, 1'b0);
    applyStimulus(2, 1'b0, 32'h10, 32'h0);
    applyAbort(2, 32'h14, 32'h8888_8888, 1, 1'b1);
    applyStimulus(2, 1'b1, 32'h14, 32'h4444_0014);
    applyStimulus(2, 1'b0, 32'h14, 32'h0);

    for (int u = 0; u < NU; u++) begin
      for (int it = 0; it < 25; it++) begin
        r = int'($urandom_range(0, 9));
        a = 32'($urandom_range(0, NREG - 1)) << 2;
        if (r == 7) a = a | 32'($urandom_range(1, 3));
        else if (r == 8) a = 32'($urandom_range(NREG, 64)) << 2;
        else if (r == 9) a = ($urandom | 32'h8000_0000) & 32'hFFFF_FFFC;
        applyStimulus(u, ($urandom_range(0, 1) == 1), a, $urandom);
        if ($urandom_range(0, 2) == 0) begin
          @(posedge clk); #1;
        end
      end
    end

`ifdef APB_SLV_IRQ_EN
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < NU; u++) begin
      checkOutput($sformatf("u%0d irq pulse count", u), 32'(seenIrq[u]), 32'(expIrq[u]));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
